// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - request and voice-side signal bundle for voice_scheduler
interface voice_scheduler_if #(
   parameter int NUM_VOICES     = 3,
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6,
   parameter int FIFO_DEPTH     = 4
);
   logic                        req_valid;
   logic [NOTE_WIDTH-1:0]       req_note;
   logic [DURATION_WIDTH-1:0]   req_duration;
   logic                        req_ready;
   logic [NUM_VOICES-1:0]       voice_done;
   logic [NUM_VOICES-1:0]       voice_load;
   logic [NOTE_WIDTH-1:0]       voice_note;
   logic [DURATION_WIDTH-1:0]   voice_duration;
   logic [NUM_VOICES-1:0]       voice_busy;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (
      output req_valid, req_note, req_duration, voice_done,
      input  req_ready, voice_load, voice_note, voice_duration, voice_busy, fifo_count
   );

   modport slave (
      input  req_valid, req_note, req_duration, voice_done,
      output req_ready, voice_load, voice_note, voice_duration, voice_busy, fifo_count
   );
endinterface

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - buffers note requests and dispatches them to the lowest free voice
module voice_scheduler #(
   parameter int NUM_VOICES     = 3,
   parameter int NOTE_WIDTH     = 6,
   parameter int DURATION_WIDTH = 6,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             play,
   input  logic             clear,
   input  logic             beat,
   voice_scheduler_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {V_FREE = 1'b0, V_ACTIVE = 1'b1} vstate_e;

   logic [NOTE_WIDTH-1:0]     note_mem_q [FIFO_DEPTH];
   logic [NOTE_WIDTH-1:0]     note_mem_d [FIFO_DEPTH];
   logic [DURATION_WIDTH-1:0] dur_mem_q  [FIFO_DEPTH];
   logic [DURATION_WIDTH-1:0] dur_mem_d  [FIFO_DEPTH];
   logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;

   vstate_e                   vstate_q [NUM_VOICES];
   vstate_e                   vstate_d [NUM_VOICES];
   logic [DURATION_WIDTH-1:0] rem_q    [NUM_VOICES];
   logic [DURATION_WIDTH-1:0] rem_d    [NUM_VOICES];

   logic [NUM_VOICES-1:0]     voice_load_q, voice_load_d;
   logic [NOTE_WIDTH-1:0]     voice_note_q, voice_note_d;
   logic [DURATION_WIDTH-1:0] voice_duration_q, voice_duration_d;

   logic                      push, pop, load_now, win_found;
   logic [NUM_VOICES-1:0]     free_vec, win_oh;
   logic [NOTE_WIDTH-1:0]     head_note;
   logic [DURATION_WIDTH-1:0] head_dur;

   // Winner is chosen from registered state, so a voice freed this edge waits a cycle.
   always_comb begin
      free_vec  = '0;
      win_oh    = '0;
      win_found = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         free_vec[i] = (vstate_q[i] == V_FREE);
         if (free_vec[i] && !win_found) begin
            win_oh[i] = 1'b1;
            win_found = 1'b1;
         end
      end
   end

   assign head_note     = note_mem_q[rd_ptr_q];
   assign head_dur      = dur_mem_q[rd_ptr_q];
   assign bus.req_ready = (count_q < CW'(FIFO_DEPTH)) && !clear;
   assign push          = bus.req_valid && bus.req_ready;
   assign pop           = play && !clear && (count_q != '0) && win_found;
   assign load_now      = pop && (head_dur != '0);

   always_comb begin
      note_mem_d = note_mem_q;
      dur_mem_d  = dur_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            note_mem_d[wr_ptr_q] = bus.req_note;
            dur_mem_d[wr_ptr_q]  = bus.req_duration;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Early release from the player outranks the beat countdown.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         vstate_d[i] = vstate_q[i];
         rem_d[i]    = rem_q[i];
         if (clear) begin
            vstate_d[i] = V_FREE;
            rem_d[i]    = '0;
         end else if (vstate_q[i] == V_ACTIVE) begin
            if (bus.voice_done[i]) begin
               vstate_d[i] = V_FREE;
               rem_d[i]    = '0;
            end else if (beat && play) begin
               if (rem_q[i] == DURATION_WIDTH'(1)) begin
                  vstate_d[i] = V_FREE;
                  rem_d[i]    = '0;
               end else begin
                  rem_d[i] = rem_q[i] - DURATION_WIDTH'(1);
               end
            end
         end else if (load_now && win_oh[i]) begin
            vstate_d[i] = V_ACTIVE;
            rem_d[i]    = head_dur;
         end
      end
   end

   always_comb begin
      voice_load_d     = '0;
      voice_note_d     = voice_note_q;
      voice_duration_d = voice_duration_q;
      if (load_now) begin
         voice_load_d     = win_oh;
         voice_note_d     = head_note;
         voice_duration_d = head_dur;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            note_mem_q[i] <= '0;
            dur_mem_q[i]  <= '0;
         end
         for (int i = 0; i < NUM_VOICES; i++) begin
            vstate_q[i] <= V_FREE;
            rem_q[i]    <= '0;
         end
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         count_q          <= '0;
         voice_load_q     <= '0;
         voice_note_q     <= '0;
         voice_duration_q <= '0;
      end else begin
         note_mem_q       <= note_mem_d;
         dur_mem_q        <= dur_mem_d;
         vstate_q         <= vstate_d;
         rem_q            <= rem_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         count_q          <= count_d;
         voice_load_q     <= voice_load_d;
         voice_note_q     <= voice_note_d;
         voice_duration_q <= voice_duration_d;
      end
   end

   assign bus.voice_load     = voice_load_q;
   assign bus.voice_note     = voice_note_q;
   assign bus.voice_duration = voice_duration_q;
   assign bus.voice_busy     = ~free_vec;
   assign bus.fifo_count     = count_q;
endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed scoreboard bench for voice_scheduler
module tb_voice_scheduler;
   localparam int NV = 3;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int FD = 4;

   logic clk = 1'b0;
   logic reset, play, clear, beat;

   voice_scheduler_if #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .DURATION_WIDTH(DW), .FIFO_DEPTH(FD)) bus();

   voice_scheduler #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .DURATION_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
      .clk   (clk),
      .reset (reset),
      .play  (play),
      .clear (clear),
      .beat  (beat),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   logic [14:0] exp_q[$];
   logic [14:0] mon_e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [5:0] n, input logic [5:0] d);
      bus.req_valid    = 1'b1;
      bus.req_note     = n;
      bus.req_duration = d;
      step();
      bus.req_valid    = 1'b0;
   endtask

   task automatic do_beat();
      beat = 1'b1;
      step();
      beat = 1'b0;
   endtask

   task automatic expect_load(input logic [2:0] oh, input logic [5:0] n, input logic [5:0] d);
      exp_q.push_back({oh, n, d});
   endtask

   always @(negedge clk) begin
      if (!reset && bus.voice_load != '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_load", 32'(bus.voice_load), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("load_onehot", 32'(bus.voice_load), 32'(mon_e[14:12]));
            chk("load_note", 32'(bus.voice_note), 32'(mon_e[11:6]));
            chk("load_duration", 32'(bus.voice_duration), 32'(mon_e[5:0]));
         end
      end
   end

   initial begin
      reset = 1'b1; play = 1'b0; clear = 1'b0; beat = 1'b0;
      bus.req_valid = 1'b0; bus.req_note = '0; bus.req_duration = '0; bus.voice_done = '0;
      #12;
      chk("rst_load", 32'(bus.voice_load), 32'd0);
      chk("rst_busy", 32'(bus.voice_busy), 32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_note", 32'(bus.voice_note), 32'd0);
      chk("rst_dur", 32'(bus.voice_duration), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      reset = 1'b0;
      step();

      // single note, latency and 4-beat expiry
      play = 1'b1;
      expect_load(3'b001, 6'd12, 6'd4);
      push_req(6'd12, 6'd4);
      chk("t1_no_load_yet", 32'(bus.voice_load), 32'd0);
      chk("t1_count1", 32'(bus.fifo_count), 32'd1);
      step();
      chk("t1_load_now", 32'(bus.voice_load), 32'b001);
      chk("t1_busy", 32'(bus.voice_busy), 32'b001);
      chk("t1_count0", 32'(bus.fifo_count), 32'd0);
      step();
      chk("t1_one_cycle", 32'(bus.voice_load), 32'd0);
      do_beat(); do_beat(); do_beat();
      chk("t1_busy_b3", 32'(bus.voice_busy), 32'b001);
      do_beat();
      chk("t1_free_b4", 32'(bus.voice_busy), 32'b000);

      // four back-to-back, fourth waits for voice_done[1]
      expect_load(3'b001, 6'd1, 6'd8);
      expect_load(3'b010, 6'd2, 6'd8);
      expect_load(3'b100, 6'd3, 6'd8);
      expect_load(3'b010, 6'd4, 6'd8);
      push_req(6'd1, 6'd8);
      push_req(6'd2, 6'd8);
      push_req(6'd3, 6'd8);
      push_req(6'd4, 6'd8);
      chk("t2_count1", 32'(bus.fifo_count), 32'd1);
      chk("t2_all_busy", 32'(bus.voice_busy), 32'b111);
      step(); step();
      chk("t2_waiting", 32'(bus.fifo_count), 32'd1);
      bus.voice_done = 3'b010;
      step();
      bus.voice_done = '0;
      chk("t2_v1_freed", 32'(bus.voice_busy), 32'b101);
      step();
      chk("t2_refilled", 32'(bus.voice_busy), 32'b111);
      chk("t2_drained", 32'(bus.fifo_count), 32'd0);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t2_clear_busy", 32'(bus.voice_busy), 32'd0);

      // fill while paused, overflow ignored, then drain three
      play = 1'b0;
      push_req(6'd20, 6'd9);
      push_req(6'd21, 6'd9);
      push_req(6'd22, 6'd9);
      push_req(6'd23, 6'd9);
      chk("t3_full_ready", 32'(bus.req_ready), 32'd0);
      chk("t3_full_count", 32'(bus.fifo_count), 32'd4);
      push_req(6'd24, 6'd9);
      chk("t3_overflow_ignored", 32'(bus.fifo_count), 32'd4);
      expect_load(3'b001, 6'd20, 6'd9);
      expect_load(3'b010, 6'd21, 6'd9);
      expect_load(3'b100, 6'd22, 6'd9);
      play = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("t3_left_one", 32'(bus.fifo_count), 32'd1);
      chk("t3_busy", 32'(bus.voice_busy), 32'b111);
      chk("t3_ready_again", 32'(bus.req_ready), 32'd1);
      clear = 1'b1; step(); clear = 1'b0;

      // pause freezes the countdown
      expect_load(3'b001, 6'd30, 6'd2);
      push_req(6'd30, 6'd2);
      step();
      play = 1'b0;
      do_beat(); do_beat(); do_beat();
      chk("t4_frozen", 32'(bus.voice_busy), 32'b001);
      play = 1'b1;
      do_beat();
      chk("t4_after_b1", 32'(bus.voice_busy), 32'b001);
      do_beat();
      chk("t4_after_b2", 32'(bus.voice_busy), 32'b000);

      // zero-duration entry is discarded
      expect_load(3'b001, 6'd41, 6'd5);
      push_req(6'd40, 6'd0);
      push_req(6'd41, 6'd5);
      chk("t5_zero_no_load", 32'(bus.voice_load), 32'd0);
      chk("t5_count", 32'(bus.fifo_count), 32'd1);
      step();
      chk("t5_busy", 32'(bus.voice_busy), 32'b001);
      step();
      chk("t5_note_held", 32'(bus.voice_note), 32'd41);
      clear = 1'b1; step(); clear = 1'b0;

      // clear with busy voices and queued entries
      expect_load(3'b001, 6'd60, 6'd10);
      expect_load(3'b010, 6'd61, 6'd10);
      push_req(6'd60, 6'd10);
      push_req(6'd61, 6'd10);
      step();
      play = 1'b0;
      push_req(6'd62, 6'd10);
      push_req(6'd63, 6'd10);
      chk("t6_count2", 32'(bus.fifo_count), 32'd2);
      chk("t6_busy2", 32'(bus.voice_busy), 32'b011);
      clear = 1'b1;
      bus.req_valid = 1'b1;
      #1;
      chk("t6_ready_clear", 32'(bus.req_ready), 32'd0);
      step();
      clear = 1'b0;
      bus.req_valid = 1'b0;
      chk("t6_count0", 32'(bus.fifo_count), 32'd0);
      chk("t6_busy0", 32'(bus.voice_busy), 32'd0);
      chk("t6_load0", 32'(bus.voice_load), 32'd0);

      // asynchronous reset mid-countdown
      play = 1'b1;
      expect_load(3'b001, 6'd50, 6'd6);
      push_req(6'd50, 6'd6);
      step();
      do_beat();
      #3 reset = 1'b1;
      #1;
      chk("t7_busy", 32'(bus.voice_busy), 32'd0);
      chk("t7_note", 32'(bus.voice_note), 32'd0);
      chk("t7_dur", 32'(bus.voice_duration), 32'd0);
      chk("t7_count", 32'(bus.fifo_count), 32'd0);
      chk("t7_load", 32'(bus.voice_load), 32'd0);
      #10 reset = 1'b0;
      step();

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Shares a fixed pool of note-player voices among note requests issued by the song reader.
- Buffers incoming note/duration requests in a small FIFO and dispatches each one to the lowest-indexed free voice.
- Tracks each voice's remaining duration in beats and frees the voice on expiry or when its player reports done.
- Sits between the song reader and the note players; replaces ad-hoc combinational voice selection with registered, arbitrated dispatch.

Parameters:
NUM_VOICES, 3, number of note-player voices managed
NOTE_WIDTH, 6, note code width
DURATION_WIDTH, 6, duration width in beats
FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
play  input  1  1 = run; 0 = pause dispatch and duration countdown
clear  input  1  synchronous flush: empty FIFO, free all voices
beat  input  1  one-cycle beat strobe
req_valid  input  1  note request valid
req_note  input  NOTE_WIDTH  requested note
req_duration  input  DURATION_WIDTH  requested duration in beats
req_ready  output  1  FIFO can accept (count < FIFO_DEPTH)
voice_done  input  NUM_VOICES  per-voice early-release pulse from note players
voice_load  output  NUM_VOICES  one-hot, one-cycle load strobe to the selected voice
voice_note  output  NOTE_WIDTH  note for the strobed voice (valid while voice_load != 0)
voice_duration  output  DURATION_WIDTH  duration for the strobed voice
voice_busy  output  NUM_VOICES  per-voice ACTIVE flag
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async): FIFO empty, pointers 0, fifo_count=0, all voices FREE, remaining counters 0, voice_load=0, voice_note=0, voice_duration=0, voice_busy=0.
- req_ready = (fifo_count < FIFO_DEPTH) and not clear. The push happens on an edge with req_valid && req_ready.
- When full, req_ready=0 even if a pop occurs in the same cycle; there is no push-through.
- Push and pop in the same cycle (not full) leave the count unchanged.
- Dispatch condition in a cycle: play=1, clear=0, FIFO non-empty, and at least one voice_busy bit = 0.
- On dispatch: pop the head; the winner is the lowest index i with voice_busy[i]=0.
  - At the edge, register voice_load = one-hot(i), voice_note/voice_duration = head fields, voice i -> ACTIVE, remaining[i] = head duration.
- Latency: a request pushed at edge k, with a free voice and play=1, produces voice_load high in the cycle following edge k+1. At most one dispatch per cycle.
- Zero duration: a head entry with duration 0 is popped with no voice_load and no voice state change.
- voice_load is high for exactly one cycle per dispatch. voice_note and voice_duration hold their last values otherwise.
- Per-voice FSM, FREE <-> ACTIVE:
  - ACTIVE with beat=1 and play=1: remaining decrements; at remaining==1 the voice goes to FREE at the same edge and remaining becomes 0.
  - ACTIVE with voice_done[i]=1: goes to FREE at that edge, with or without play; this has priority over decrement.
  - voice_done on a FREE voice is ignored.
  - A voice freed at edge k is eligible for dispatch in the decision cycle after edge k, never in the same cycle.
- play=0: no dispatch, counters frozen, FIFO still accepts pushes, voice_done still frees voices.
- clear=1 at an edge: FIFO empty, all voices FREE, remaining=0, voice_load=0. Clear overrides push, dispatch and countdown in that cycle.
- No voice stealing: when all voices are busy, requests wait in the FIFO.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-operation returns every output to its reset value immediately.

Test Plan:
- Reset, play=1, push note 12 dur 4: voice_load=001 one cycle, two edges after the push; voice_note=12, voice_duration=4. voice_busy[0] clears at the 4th beat.
- Push 4 requests back-to-back (durations 8): loads go to voices 0, 1, 2 on consecutive cycles. The 4th request waits (fifo_count=1) until voice_done[1] pulses, then dispatches with voice_load=010.
- Fill the FIFO with play=0 (4 pushes): req_ready=0, a 5th req_valid is ignored, fifo_count=4. Raising play drains to 3 loads, leaving fifo_count=1.
- Voice 0 ACTIVE, remaining=2; hold play=0 across 3 beats: remaining stays 2. Then play=1 and 2 beats: voice_busy[0] falls after the 2nd beat.
- Push a dur-0 request, then a dur-5 request: the first produces no voice_load, the second loads voice 0.
- With 2 voices busy and 2 FIFO entries, assert clear: fifo_count=0, voice_busy=000, no voice_load. Assert reset mid-countdown: all outputs zero asynchronously.
